data_mem_responder: RTL and testbench

- Memory-side responder for the CPU data port: services one load or one store request at a time.
- Accepts requests on a level-sampled enable/write-enable interface, the same signalling the core drives toward data memory.
- Inserts a configurable number of wait states, then returns a one-cycle `ready` pulse; on a load, read data is valid in that same cycle.
- Sits between the core's data port and a word-addressed on-chip RAM array held inside this block.

---
 rtl/data_mem_responder_if.sv | 34 +++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between the core's data port and the data-memory
//   responder.
//   master : the core side; drives the request, observes the response.
//   slave  : the memory side; observes the request, drives the response.
//   Signals:
//     req_en    request valid (level sampled while busy=0)
//     req_we    1 = store, 0 = load
//     req_addr  32-bit word address
//     req_wdata store data
//     rdata     registered load data
//     ready     one-cycle completion pulse
//     busy      a request is in flight
//     addr_err  one-cycle out-of-range flag, coincident with ready
interface data_mem_responder_if;
    logic        req_en;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output req_en, req_we, req_addr, req_wdata,
        input  rdata, ready, busy, addr_err
    );

    modport slave (
        input  req_en, req_we, req_addr, req_wdata,
        output rdata, ready, busy, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one load or store at
//   a time, inserts WAIT_CYCLES wait states, then performs the access on an
//   internal word-addressed array and returns a one-cycle ready pulse (with
//   load data valid in that same cycle).
//   Parameters:
//     ADDR_BITS   word-address width; array holds 2^ADDR_BITS 32-bit words
//     WAIT_CYCLES wait states between accept and access (0..15)
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low
//     bus    data_mem_responder_if.slave request/response bundle
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Counter preload on entry to WAIT; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        mem_we;

    logic [31:0] mem_q [DEPTH];

    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;

    assign in_range = (addr_q[31:ADDR_BITS] == '0);
    assign idx      = addr_q[ADDR_BITS-1:0];

    // State register and control/response flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched request: pure data, only meaningful while busy.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Array is never cleared; a reset edge suppresses any in-flight write.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_en) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        if (state_q == S_IDLE && bus.req_en) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
        end

        // The ACCESS cycle ends on the completion edge; ready is visible after it.
        if (state_q == S_ACCESS) begin
            ready_d = 1'b1;
            err_d   = ~in_range;
            if (we_q) begin
                mem_we = in_range;
            end else begin
                rdata_d = in_range ? mem_q[idx] : 32'h0;
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.addr_err = err_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives three responders (0, 1 and 3 wait states, ADDR_BITS=10) from one
//   shared request stream and checks every cycle against a transaction-level
//   model; directed sequences pin specific literal results.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder_if if0();
    data_mem_responder_if if1();
    data_mem_responder_if if2();

    assign if0.req_en = en;  assign if0.req_we = we;  assign if0.req_addr = addr;  assign if0.req_wdata = wdata;
    assign if1.req_en = en;  assign if1.req_we = we;  assign if1.req_addr = addr;  assign if1.req_wdata = wdata;
    assign if2.req_en = en;  assign if2.req_we = we;  assign if2.req_addr = addr;  assign if2.req_wdata = wdata;

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u2 (.clk(clk), .reset(rst_n), .bus(if2.slave));

    logic [31:0] o_rdata [3];
    logic        o_ready [3];
    logic        o_busy  [3];
    logic        o_err   [3];

    assign o_rdata[0] = if0.rdata;  assign o_ready[0] = if0.ready;  assign o_busy[0] = if0.busy;  assign o_err[0] = if0.addr_err;
    assign o_rdata[1] = if1.rdata;  assign o_ready[1] = if1.ready;  assign o_busy[1] = if1.busy;  assign o_err[1] = if1.addr_err;
    assign o_rdata[2] = if2.rdata;  assign o_ready[2] = if2.ready;  assign o_busy[2] = if2.busy;  assign o_err[2] = if2.addr_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each responder: a request accepted at an edge while not busy completes
    // WAIT+1 edges later; reset drops everything in flight.
    int          wt [3] = '{0, 1, 3};
    bit          armed = 1'b0;
    bit          m_busy  [3];
    int          m_left  [3];
    logic        m_we    [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_rdata [3];
    logic        m_ready [3];
    logic        m_err   [3];
    logic [31:0] mm [3][1024];

    initial begin
        bit inr;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    m_busy[d]  = 1'b0;
                    m_ready[d] = 1'b0;
                    m_err[d]   = 1'b0;
                    m_rdata[d] = 32'h0;
                end else begin
                    m_ready[d] = 1'b0;
                    m_err[d]   = 1'b0;
                    if (m_busy[d]) begin
                        m_left[d] = m_left[d] - 1;
                        if (m_left[d] == 0) begin
                            m_busy[d]  = 1'b0;
                            m_ready[d] = 1'b1;
                            inr = (m_addr[d][31:10] == 22'h0);
                            m_err[d] = !inr;
                            if (m_we[d]) begin
                                if (inr) mm[d][m_addr[d][9:0]] = m_wdata[d];
                            end else begin
                                m_rdata[d] = inr ? mm[d][m_addr[d][9:0]] : 32'h0;
                            end
                        end
                    end else if (en) begin
                        m_busy[d]  = 1'b1;
                        m_left[d]  = wt[d] + 1;
                        m_we[d]    = we;
                        m_addr[d]  = addr;
                        m_wdata[d] = wdata;
                    end
                end
            end
            if (!rst_n) armed = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("d%0d_ready", d), {31'h0, o_ready[d]}, {31'h0, m_ready[d]});
                    chk($sformatf("d%0d_busy", d),  {31'h0, o_busy[d]},  {31'h0, m_busy[d]});
                    chk($sformatf("d%0d_err", d),   {31'h0, o_err[d]},   {31'h0, m_err[d]});
                    chk($sformatf("d%0d_rdata", d), o_rdata[d], m_rdata[d]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd);
        en = 1'b1; we = w; addr = a; wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", {31'h0, o_ready[1]}, 32'h0);
            chk("idle_busy",  {31'h0, o_busy[1]},  32'h0);
            chk("idle_err",   {31'h0, o_err[1]},   32'h0);
            chk("idle_rdata", o_rdata[1], 32'h0);
        end

        // Preload indices 0..15 with i+1 in every responder.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, i + 1);
            repeat (5) tick();
        end
        idle(6);

        // Store then load, one wait state.
        drive(1'b1, 32'd5, 32'hDEADBEEF);
        tick(); en = 1'b0;
        chk("st5_busy0",  {31'h0, o_busy[1]},  32'h1);
        chk("st5_ready0", {31'h0, o_ready[1]}, 32'h0);
        tick();
        chk("st5_busy1",  {31'h0, o_busy[1]},  32'h1);
        chk("st5_ready1", {31'h0, o_ready[1]}, 32'h0);
        tick();
        chk("st5_ready",  {31'h0, o_ready[1]}, 32'h1);
        chk("st5_busyr",  {31'h0, o_busy[1]},  32'h0);
        idle(6);
        drive(1'b0, 32'd5, 32'h0);
        tick(); en = 1'b0; tick(); tick();
        chk("ld5_ready", {31'h0, o_ready[1]}, 32'h1);
        chk("ld5_rdata", o_rdata[1], 32'hDEADBEEF);
        idle(6);

        // Back-to-back loads, no wait states, req_en held.
        drive(1'b0, 32'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b_busy", {31'h0, o_busy[0]}, 32'h1);
            tick();
            chk("b2b_ready", {31'h0, o_ready[0]}, 32'h1);
            chk("b2b_rdata", o_rdata[0], k + 1);
            if (k < 3) addr = k + 1; else en = 1'b0;
        end
        idle(6);

        // Out of range.
        drive(1'b1, 32'h00000400, 32'h12345678);
        tick(); en = 1'b0; tick(); tick();
        chk("oor_st_ready", {31'h0, o_ready[1]}, 32'h1);
        chk("oor_st_err",   {31'h0, o_err[1]},   32'h1);
        idle(6);
        drive(1'b0, 32'd0, 32'h0);
        tick(); en = 1'b0; tick(); tick();
        chk("oor_ld0_rdata", o_rdata[1], 32'h1);
        chk("oor_ld0_err",   {31'h0, o_err[1]}, 32'h0);
        idle(6);
        drive(1'b0, 32'h80000000, 32'h0);
        tick(); en = 1'b0; tick(); tick();
        chk("oor_ld_ready", {31'h0, o_ready[1]}, 32'h1);
        chk("oor_ld_err",   {31'h0, o_err[1]},   32'h1);
        chk("oor_ld_rdata", o_rdata[1], 32'h0);
        idle(6);

        // Requests while busy are ignored, three wait states.
        drive(1'b1, 32'd7, 32'hA5A5A5A5);
        tick();
        drive(1'b1, 32'd8, 32'h1);
        tick(); en = 1'b0;
        tick(); en = 1'b1;
        tick(); en = 1'b0;
        tick();
        chk("ign_ready", {31'h0, o_ready[2]}, 32'h1);
        idle(6);
        drive(1'b0, 32'd8, 32'h0);
        tick(); en = 1'b0; repeat (4) tick();
        chk("ign_ld8", o_rdata[2], 32'd9);
        idle(6);
        drive(1'b0, 32'd7, 32'h0);
        tick(); en = 1'b0; repeat (4) tick();
        chk("ign_ld7", o_rdata[2], 32'hA5A5A5A5);
        idle(6);

        // Reset during WAIT aborts the store.
        drive(1'b1, 32'd9, 32'hCAFEF00D);
        tick(); en = 1'b0;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        chk("rst_busy",  {31'h0, o_busy[2]},  32'h0);
        chk("rst_ready", {31'h0, o_ready[2]}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_noready", {31'h0, o_ready[2]}, 32'h0);
        end
        drive(1'b0, 32'd9, 32'h0);
        tick(); en = 1'b0; repeat (4) tick();
        chk("rst_ld9", o_rdata[2], 32'd10);
        idle(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            en    = ($urandom % 3) != 0;
            we    = $urandom % 2;
            wdata = $urandom;
            if (($urandom % 4) == 0) begin
                a = $urandom | (32'h1 << $urandom_range(31, 10));
            end else begin
                a = $urandom % 16;
            end
            addr  = a;
            rst_n = ($urandom % 100) != 0;
            tick();
        end
        rst_n = 1'b1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
